tdm_demux_4: RTL

- Four-channel time-division demultiplexer; the receive-side counterpart of the 4:1 multiplexer.
- Accepts a serial stream of WIDTH-bit words, one per slot, with a frame-sync marker on slot 0.
- Steers each word into one of four held output registers using an internal slot counter.
- Tracks frame lock and flags sync errors; sits between a TDM link and per-channel consumers.

---
 rtl/tdm_demux_4.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tdm_demux_4.sv
// Four-channel TDM receive demultiplexer: steers slot words into held channel
// registers, tracks frame lock from the slot-0 sync marker and flags framing errors.
module tdm_demux_4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    output logic             frame_valid,
    output logic [1:0]       sel,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [WIDTH-1:0] out3_q, out3_d;
    logic [3:0]       out_valid_q, out_valid_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;

    // Handshake: in_valid qualifies in_data/in_sync for one cycle; there is no
    // ready, every valid word is consumed (stored or dropped) on the same edge.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        out0_d        = out0_q;
        out1_d        = out1_q;
        out2_d        = out2_q;
        out3_d        = out3_q;
        out_valid_d   = 4'b0000;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_sync) begin
                        out0_d      = in_data;
                        out_valid_d = 4'b0001;
                        sel_d       = 2'd1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sync) begin
                        // An early sync restarts the frame but keeps lock.
                        sync_err_d  = (sel_q != 2'd0);
                        out0_d      = in_data;
                        out_valid_d = 4'b0001;
                        sel_d       = 2'd1;
                    end else if (sel_q == 2'd0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        sel_d      = 2'd0;
                    end else begin
                        case (sel_q)
                            2'd1:    out1_d = in_data;
                            2'd2:    out2_d = in_data;
                            default: out3_d = in_data;
                        endcase
                        out_valid_d   = 4'b0001 << sel_q;
                        frame_valid_d = (sel_q == 2'd3);
                        sel_d         = sel_q + 2'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            sel_q         <= 2'd0;
            out0_q        <= '0;
            out1_q        <= '0;
            out2_q        <= '0;
            out3_q        <= '0;
            out_valid_q   <= 4'b0000;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            out0_q        <= out0_d;
            out1_q        <= out1_d;
            out2_q        <= out2_d;
            out3_q        <= out3_d;
            out_valid_q   <= out_valid_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign out0        = out0_q;
    assign out1        = out1_q;
    assign out2        = out2_q;
    assign out3        = out3_q;
    assign out_valid   = out_valid_q;
    assign frame_valid = frame_valid_q;
    assign sel         = sel_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = sync_err_q;

endmodule
